// File: rtl/space_invaders_pkg.sv
// Shared geometry, index and state types for the alien collision logic.
package space_invaders_pkg;

  localparam int ROWS      = 4;
  localparam int COLS      = 8;
  localparam int N_ALIENS  = ROWS * COLS;
  localparam int ALIEN_W   = 8;
  localparam int ALIEN_H   = 8;
  localparam int H_SPACING = 12;
  localparam int V_SPACING = 12;
  localparam int X_W       = 8;
  localparam int Y_W       = 7;
  localparam int TOP_Y     = 0;

  localparam int IDX_W = $clog2(N_ALIENS);
  localparam int ROW_W = $clog2(ROWS);
  localparam int COL_W = $clog2(COLS);

  localparam logic [Y_W-1:0] TOP_Y_V = Y_W'(TOP_Y);

  typedef logic [IDX_W-1:0] alien_idx_t;

  localparam alien_idx_t IDX_LAST = alien_idx_t'(N_ALIENS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HIT  = 2'd2,
    DONE = 2'd3
  } hit_state_t;

  function automatic logic [ROW_W-1:0] idx_row(input alien_idx_t idx);
    return ROW_W'(idx / alien_idx_t'(COLS));
  endfunction

  function automatic logic [COL_W-1:0] idx_col(input alien_idx_t idx);
    return COL_W'(idx % alien_idx_t'(COLS));
  endfunction

endpackage

// File: rtl/alien_box_compare.sv
// Point-in-hitbox test for one alien of the fleet grid.
// Coordinates are widened by one bit so the far edge of the last column/row never wraps.
module alien_box_compare
  import space_invaders_pkg::*;
(
  input  logic [X_W-1:0]   i_origin_x,
  input  logic [Y_W-1:0]   i_origin_y,
  input  logic [ROW_W-1:0] i_row,
  input  logic [COL_W-1:0] i_col,
  input  logic [X_W-1:0]   i_rocket_x,
  input  logic [Y_W-1:0]   i_rocket_y,
  output logic             o_inside
);

  localparam logic [X_W:0] X_PITCH = (X_W+1)'(H_SPACING);
  localparam logic [Y_W:0] Y_PITCH = (Y_W+1)'(V_SPACING);
  localparam logic [X_W:0] X_SIZE  = (X_W+1)'(ALIEN_W);
  localparam logic [Y_W:0] Y_SIZE  = (Y_W+1)'(ALIEN_H);

  logic [X_W:0] w_x0;
  logic [X_W:0] w_x1;
  logic [Y_W:0] w_y0;
  logic [Y_W:0] w_y1;
  logic [X_W:0] w_rx;
  logic [Y_W:0] w_ry;
  logic         w_in_x;
  logic         w_in_y;

  assign w_x0 = {1'b0, i_origin_x} + ({{(X_W+1-COL_W){1'b0}}, i_col} * X_PITCH);
  assign w_y0 = {1'b0, i_origin_y} + ({{(Y_W+1-ROW_W){1'b0}}, i_row} * Y_PITCH);
  assign w_x1 = w_x0 + X_SIZE;
  assign w_y1 = w_y0 + Y_SIZE;
  assign w_rx = {1'b0, i_rocket_x};
  assign w_ry = {1'b0, i_rocket_y};

  // Half-open box: [x0, x0+W) x [y0, y0+H)
  assign w_in_x   = (w_rx >= w_x0) && (w_rx < w_x1);
  assign w_in_y   = (w_ry >= w_y0) && (w_ry < w_y1);
  assign o_inside = w_in_x && w_in_y;

endmodule

// File: rtl/alien_hit_responder.sv
// Player-shot collision responder: top-boundary check, then a one-alien-per-clock
// grid scan that kills the lowest-index alive alien under the rocket tip.
//
// state | meaning
// IDLE  | waiting for rocketValid; latches rocket and fleet origin
// SCAN  | testing alien r_idx against the latched rocket position
// HIT   | eraseEn for alien r_idx; alien cleared and hitCount bumped on exit
// DONE  | checkDone pulse; result flags updated on entry
module alien_hit_responder
  import space_invaders_pkg::*;
(
  input  logic                clk,
  input  logic                resetn,
  input  logic                rocketValid,
  input  logic [X_W-1:0]      rocketX,
  input  logic [Y_W-1:0]      rocketY,
  input  logic [X_W-1:0]      gridX,
  input  logic [Y_W-1:0]      gridY,
  input  logic                fleetReset,
  output logic                busy,
  output logic                checkDone,
  output logic                collidedWithAlien,
  output logic                topReached,
  output logic                eraseEn,
  output logic [ROW_W-1:0]    eraseRow,
  output logic [COL_W-1:0]    eraseCol,
  output logic [N_ALIENS-1:0] aliveMask,
  output logic [7:0]          hitCount,
  output logic                allCleared
);

  hit_state_t          r_state;
  hit_state_t          w_next_state;
  logic [X_W-1:0]      r_rocket_x;
  logic [Y_W-1:0]      r_rocket_y;
  logic [X_W-1:0]      r_grid_x;
  logic [Y_W-1:0]      r_grid_y;
  alien_idx_t          r_idx;
  logic [N_ALIENS-1:0] r_alive;
  logic [7:0]          r_hit_count;
  logic                r_collided;
  logic                r_top;
  logic [ROW_W-1:0]    r_erase_row;
  logic [COL_W-1:0]    r_erase_col;

  logic [ROW_W-1:0]    w_row;
  logic [COL_W-1:0]    w_col;
  logic                w_inside;
  logic                w_hit;
  logic                w_at_top;

  assign w_row    = idx_row(r_idx);
  assign w_col    = idx_col(r_idx);
  assign w_hit    = r_alive[r_idx] && w_inside;
  assign w_at_top = (rocketY <= TOP_Y_V);

  alien_box_compare u_box (
    .i_origin_x (r_grid_x),
    .i_origin_y (r_grid_y),
    .i_row      (w_row),
    .i_col      (w_col),
    .i_rocket_x (r_rocket_x),
    .i_rocket_y (r_rocket_y),
    .o_inside   (w_inside)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (fleetReset) begin
      w_next_state = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (rocketValid) begin
            w_next_state = w_at_top ? DONE : SCAN;
          end
        end
        SCAN: begin
          if (w_hit) begin
            w_next_state = HIT;
          end else if (r_idx == IDX_LAST) begin
            w_next_state = DONE;
          end
        end
        HIT:     w_next_state = DONE;
        DONE:    w_next_state = IDLE;
        default: w_next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rocket_x  <= '0;
      r_rocket_y  <= '0;
      r_grid_x    <= '0;
      r_grid_y    <= '0;
      r_idx       <= '0;
      r_alive     <= '1;
      r_hit_count <= '0;
      r_collided  <= 1'b0;
      r_top       <= 1'b0;
      r_erase_row <= '0;
      r_erase_col <= '0;
    end else if (fleetReset) begin
      r_alive     <= '1;
      r_hit_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (rocketValid) begin
            r_rocket_x <= rocketX;
            r_rocket_y <= rocketY;
            r_grid_x   <= gridX;
            r_grid_y   <= gridY;
            r_idx      <= '0;
            if (w_at_top) begin
              r_top      <= 1'b1;
              r_collided <= 1'b0;
            end
          end
        end
        SCAN: begin
          if (w_hit) begin
            r_erase_row <= w_row;
            r_erase_col <= w_col;
          end else if (r_idx == IDX_LAST) begin
            r_top      <= 1'b0;
            r_collided <= 1'b0;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        HIT: begin
          r_alive[r_idx] <= 1'b0;
          if (r_hit_count != 8'hFF) begin
            r_hit_count <= r_hit_count + 8'd1;
          end
          r_top      <= 1'b0;
          r_collided <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign busy              = (r_state != IDLE);
  assign checkDone         = (r_state == DONE);
  assign eraseEn           = (r_state == HIT);
  assign eraseRow          = r_erase_row;
  assign eraseCol          = r_erase_col;
  assign collidedWithAlien = r_collided;
  assign topReached        = r_top;
  assign aliveMask         = r_alive;
  assign hitCount          = r_hit_count;
  assign allCleared        = (r_alive == '0);

endmodule
